// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle 16-function ALU plus shift-add multiply and
// restoring divide, with a Start/Busy/Done handshake and registered results.
module iterative_alu #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Mode,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] HiOut,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_ITER} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             wf_r;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    // FlagsOut = {Z, C, N, O}
    logic c_in;
    assign c_in = FlagsOut[2];

    function automatic logic top(input logic [WIDTH-1:0] x, input logic h);
        return h ? x[HALF-1] : x[WIDTH-1];
    endfunction

    // ---------------- single-cycle ALU ----------------
    logic             half;
    logic [3:0]       fn;
    logic [WIDTH-1:0] msk, top_bit, opa, opb, add_b;
    logic             add_c;
    logic [WIDTH:0]   sum;
    logic             sum_c, sum_o;
    logic [WIDTH-1:0] alu_res;
    logic             c_new, o_new;
    logic [3:0]       alu_flags;

    assign half    = ~FunSel[4];
    assign fn      = FunSel[3:0];
    assign msk     = half ? {{HALF{1'b0}}, {HALF{1'b1}}} : {WIDTH{1'b1}};
    assign top_bit = msk ^ (msk >> 1);
    assign opa     = A & msk;
    assign opb     = B & msk;
    assign add_b   = (fn == 4'h6) ? (~opb & msk) : opb;
    assign add_c   = (fn == 4'h6) ? 1'b1 : ((fn == 4'h5) ? c_in : 1'b0);
    assign sum     = {1'b0, opa} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
    assign sum_c   = half ? sum[HALF] : sum[WIDTH];
    assign sum_o   = (top(opa, half) == top(add_b, half)) &&
                     (top(sum[WIDTH-1:0], half) != top(opa, half));

    always_comb begin
        alu_res = '0;
        c_new   = FlagsOut[2];
        o_new   = FlagsOut[0];
        case (fn)
            4'h0: alu_res = opa;
            4'h1: alu_res = opb;
            4'h2: alu_res = ~opa & msk;
            4'h3: alu_res = ~opb & msk;
            4'h4, 4'h5, 4'h6: begin
                alu_res = sum[WIDTH-1:0] & msk;
                c_new   = sum_c;
                o_new   = sum_o;
            end
            4'h7: alu_res = opa & opb;
            4'h8: alu_res = opa | opb;
            4'h9: alu_res = opa ^ opb;
            4'hA: alu_res = ~(opa & opb) & msk;
            4'hB: begin
                alu_res = (opa << 1) & msk;
                c_new   = top(opa, half);
            end
            4'hC: begin
                alu_res = opa >> 1;
                c_new   = opa[0];
            end
            4'hD: begin
                alu_res = (opa >> 1) | (top(opa, half) ? top_bit : '0);
                c_new   = opa[0];
            end
            4'hE: begin
                alu_res = ((opa << 1) | {{(WIDTH-1){1'b0}}, c_in}) & msk;
                c_new   = top(opa, half);
            end
            4'hF: begin
                alu_res = (opa >> 1) | (c_in ? top_bit : '0);
                c_new   = opa[0];
            end
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = {alu_res == '0, c_new, top(alu_res, half), o_new};

    // ---------------- one iteration of MUL / DIV ----------------
    // MUL: {p_hi,p_lo} holds partial product and remaining multiplier bits.
    // DIV: p_hi is the partial remainder, p_lo shifts dividend out / quotient in.
    logic [WIDTH:0]   mul_add;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] nx_hi, nx_lo;

    assign mul_add   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
    assign div_shift = {p_hi, p_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand};
    assign div_diff  = div_shift[WIDTH-1:0] - mcand;

    always_comb begin
        if (is_div) begin
            nx_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            nx_lo = {p_lo[WIDTH-2:0], div_ge};
        end else begin
            nx_hi = mul_add[WIDTH:1];
            nx_lo = {mul_add[0], p_lo[WIDTH-1:1]};
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            wf_r     <= 1'b0;
            mcand    <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            ALUOut   <= '0;
            HiOut    <= '0;
            FlagsOut <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: if (Start) begin
                    if (Mode == 2'b01 || (Mode == 2'b10 && B != '0)) begin
                        state  <= S_ITER;
                        Busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= Mode[1];
                        wf_r   <= WF;
                        mcand  <= B;
                        p_hi   <= '0;
                        p_lo   <= A;
                    end else if (Mode == 2'b10) begin
                        // divide by zero: saturated quotient, dividend as remainder
                        ALUOut <= '1;
                        HiOut  <= A;
                        if (WF) FlagsOut[0] <= 1'b1;
                        Done   <= 1'b1;
                    end else begin
                        ALUOut <= alu_res;
                        HiOut  <= '0;
                        if (WF) FlagsOut <= alu_flags;
                        Done   <= 1'b1;
                    end
                end
                S_ITER: begin
                    p_hi <= nx_hi;
                    p_lo <= nx_lo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state  <= S_IDLE;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        ALUOut <= nx_lo;
                        HiOut  <= nx_hi;
                        if (wf_r) begin
                            if (is_div) begin
                                FlagsOut[3] <= (nx_lo == '0);
                                FlagsOut[0] <= 1'b0;
                            end else begin
                                FlagsOut[3] <= ({nx_hi, nx_lo} == '0);
                                FlagsOut[2] <= (nx_hi != '0);
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
